// File: rtl/bless_ni_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bless_ni_pkg
// Description : Shared constants for the BLESS network interface: link and
//               address widths plus default counter width / starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package bless_ni_pkg;

    localparam int LINKWIDTH       = 32;
    localparam int ADDRBITS2       = 4;
    localparam int NI_CNTBITS      = 16;
    localparam int NI_STARVE_LIMIT = 16;

    // One injection FIFO entry: payload above destination address
    typedef struct packed {
        logic [LINKWIDTH-1:0] data;
        logic [ADDRBITS2-1:0] dst;
    } inj_entry_t;

endpackage
`default_nettype wire

// File: rtl/ni_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ni_fifo
// Description : Registered synchronous FIFO with asynchronous reset. Reads
//               return zero when empty; push while full is accepted only when
//               a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wptr_q;
    logic [c_AW-1:0]  rptr_q;
    logic [c_AW:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == c_FULL);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign rdata  = empty ? '0 : mem_q[rptr_q];
    assign count  = count_q;

    // Storage, pointers (wrap modulo DEPTH) and occupancy counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bless_ni.sv
`default_nettype none
// ============================================================================
// Module      : bless_ni
// Description : Per-node network interface for a BLESS deflection router.
//               Injection FIFO feeds the router local port; ejected flits are
//               captured into a receive FIFO. Starvation, error flags and
//               traffic counters are provided.
// Revision    : 1.0 - initial release
// ============================================================================
module bless_ni
    import bless_ni_pkg::*;
#(
    parameter int INJ_DEPTH    = 4,
    parameter int EJ_DEPTH     = 8,
    parameter int STARVE_LIMIT = NI_STARVE_LIMIT,
    parameter int CNTBITS      = NI_CNTBITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDRBITS2-1:0] ID,
    input  logic                 core_tx_valid,
    output logic                 core_tx_ready,
    input  logic [LINKWIDTH-1:0] core_tx_data,
    input  logic [ADDRBITS2-1:0] core_tx_dst,
    output logic [LINKWIDTH-1:0] in_data_inj,
    output logic [ADDRBITS2-1:0] in_srcdst_inj,
    output logic                 in_active_inj,
    input  logic                 in_accepted_inj,
    input  logic [LINKWIDTH-1:0] out_data_ej,
    input  logic [ADDRBITS2-1:0] out_srcdst_ej,
    input  logic                 out_active_ej,
    output logic                 core_rx_valid,
    input  logic                 core_rx_ready,
    output logic [LINKWIDTH-1:0] core_rx_data,
    output logic                 inj_starved,
    output logic                 ej_overflow,
    output logic                 ej_misroute,
    output logic [CNTBITS-1:0]   inj_count,
    output logic [CNTBITS-1:0]   ej_count
);

    localparam int                c_SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0]   c_LIMIT = STARVE_LIMIT[c_SW-1:0];

    // Injection path
    inj_entry_t                    w_inj_wentry;
    inj_entry_t                    w_inj_head;
    logic                          w_inj_empty;
    logic                          w_inj_full;
    logic [$clog2(INJ_DEPTH):0]    w_inj_cnt;
    logic                          w_inj_push;
    logic                          w_inj_pop;

    // Ejection path
    logic                          w_ej_empty;
    logic                          w_ej_full;
    logic [$clog2(EJ_DEPTH):0]     w_ej_cnt;
    logic                          w_ej_push;
    logic                          w_ej_pop;
    logic                          w_ej_for_me;

    logic [c_SW-1:0]               starve_q;
    logic [c_SW-1:0]               starve_d;
    logic                          starved_q;
    logic                          ovf_q;
    logic                          ovf_d;
    logic                          mis_q;
    logic                          mis_d;
    logic [CNTBITS-1:0]            inj_cnt_q;
    logic [CNTBITS-1:0]            ej_cnt_q;
    logic                          w_unused;

    // No pass-through: a full FIFO refuses the core even if the head leaves now
    assign core_tx_ready = !reset && !w_inj_full;
    assign w_inj_push    = core_tx_valid && core_tx_ready;
    assign in_active_inj = !w_inj_empty;
    assign w_inj_pop     = in_active_inj && in_accepted_inj;
    assign w_inj_wentry  = '{data: core_tx_data, dst: core_tx_dst};
    assign in_data_inj   = w_inj_head.data;
    assign in_srcdst_inj = w_inj_head.dst;

    ni_fifo #(
        .WIDTH ($bits(inj_entry_t)),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_inj_push),
        .pop   (w_inj_pop),
        .wdata (w_inj_wentry),
        .rdata (w_inj_head),
        .empty (w_inj_empty),
        .full  (w_inj_full),
        .count (w_inj_cnt)
    );

    // The router never waits, so a core pop can free the slot a full FIFO needs
    assign core_rx_valid = !w_ej_empty;
    assign w_ej_pop      = core_rx_valid && core_rx_ready;
    assign w_ej_for_me   = out_active_ej && (out_srcdst_ej == ID);
    assign w_ej_push     = w_ej_for_me && (!w_ej_full || w_ej_pop);

    ni_fifo #(
        .WIDTH (LINKWIDTH),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_ej_push),
        .pop   (w_ej_pop),
        .wdata (out_data_ej),
        .rdata (core_rx_data),
        .empty (w_ej_empty),
        .full  (w_ej_full),
        .count (w_ej_cnt)
    );

    assign w_unused = ^{w_inj_cnt, w_ej_cnt};

    // Next-state for starvation counter and sticky ejection error flags
    always_comb begin
        starve_d = starve_q;
        ovf_d    = ovf_q;
        mis_d    = mis_q;
        if (w_inj_empty || w_inj_pop) begin
            starve_d = '0;
        end else if (starve_q != c_LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
        if (out_active_ej && (out_srcdst_ej != ID)) begin
            mis_d = 1'b1;
        end
        if (w_ej_for_me && !w_ej_push) begin
            ovf_d = 1'b1;
        end
    end

    // State registers and wrapping traffic counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q  <= '0;
            starved_q <= 1'b0;
            ovf_q     <= 1'b0;
            mis_q     <= 1'b0;
            inj_cnt_q <= '0;
            ej_cnt_q  <= '0;
        end else begin
            starve_q  <= starve_d;
            starved_q <= (starve_d == c_LIMIT);
            ovf_q     <= ovf_d;
            mis_q     <= mis_d;
            if (w_inj_pop) begin
                inj_cnt_q <= inj_cnt_q + 1'b1;
            end
            if (w_ej_push) begin
                ej_cnt_q <= ej_cnt_q + 1'b1;
            end
        end
    end

    assign inj_starved = starved_q;
    assign ej_overflow = ovf_q;
    assign ej_misroute = mis_q;
    assign inj_count   = inj_cnt_q;
    assign ej_count    = ej_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bless_ni.sv
`default_nettype none
// ============================================================================
// Module      : tb_bless_ni
// Description : Self-checking bench for bless_ni: directed scenarios followed
//               by random traffic, compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bless_ni;
    import bless_ni_pkg::*;

    localparam int LW = LINKWIDTH;
    localparam int AW = ADDRBITS2;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] ID;
    logic          core_tx_valid;
    logic          core_tx_ready;
    logic [LW-1:0] core_tx_data;
    logic [AW-1:0] core_tx_dst;
    logic [LW-1:0] in_data_inj;
    logic [AW-1:0] in_srcdst_inj;
    logic          in_active_inj;
    logic          in_accepted_inj;
    logic [LW-1:0] out_data_ej;
    logic [AW-1:0] out_srcdst_ej;
    logic          out_active_ej;
    logic          core_rx_valid;
    logic          core_rx_ready;
    logic [LW-1:0] core_rx_data;
    logic          inj_starved;
    logic          ej_overflow;
    logic          ej_misroute;
    logic [15:0]   inj_count;
    logic [15:0]   ej_count;

    always #5 clock = ~clock;

    bless_ni #(
        .INJ_DEPTH    (4),
        .EJ_DEPTH     (8),
        .STARVE_LIMIT (16),
        .CNTBITS      (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ID              (ID),
        .core_tx_valid   (core_tx_valid),
        .core_tx_ready   (core_tx_ready),
        .core_tx_data    (core_tx_data),
        .core_tx_dst     (core_tx_dst),
        .in_data_inj     (in_data_inj),
        .in_srcdst_inj   (in_srcdst_inj),
        .in_active_inj   (in_active_inj),
        .in_accepted_inj (in_accepted_inj),
        .out_data_ej     (out_data_ej),
        .out_srcdst_ej   (out_srcdst_ej),
        .out_active_ej   (out_active_ej),
        .core_rx_valid   (core_rx_valid),
        .core_rx_ready   (core_rx_ready),
        .core_rx_data    (core_rx_data),
        .inj_starved     (inj_starved),
        .ej_overflow     (ej_overflow),
        .ej_misroute     (ej_misroute),
        .inj_count       (inj_count),
        .ej_count        (ej_count)
    );

    typedef struct packed {
        logic [LW-1:0] d;
        logic [AW-1:0] a;
    } ient_t;

    // Reference model state
    ient_t         injq[$];
    logic [LW-1:0] ejq[$];
    int            m_starve;
    bit            m_ovf;
    bit            m_mis;
    int            m_ic;
    int            m_ec;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        injq.delete();
        ejq.delete();
        m_starve = 0;
        m_ovf    = 0;
        m_mis    = 0;
        m_ic     = 0;
        m_ec     = 0;
    endtask

    task automatic check_all();
        chk("tx_ready",   core_tx_ready, injq.size() < 4);
        chk("inj_active", in_active_inj, injq.size() > 0);
        chk("inj_data",   in_data_inj,   injq.size() > 0 ? injq[0].d : '0);
        chk("inj_dst",    in_srcdst_inj, injq.size() > 0 ? injq[0].a : '0);
        chk("rx_valid",   core_rx_valid, ejq.size() > 0);
        chk("rx_data",    core_rx_data,  ejq.size() > 0 ? ejq[0] : '0);
        chk("starved",    inj_starved,   m_starve == 16);
        chk("overflow",   ej_overflow,   m_ovf);
        chk("misroute",   ej_misroute,   m_mis);
        chk("inj_count",  inj_count,     m_ic[15:0]);
        chk("ej_count",   ej_count,      m_ec[15:0]);
    endtask

    // One clock: derive the model's next state from the current inputs,
    // take the edge, update the model and compare every output.
    task automatic cycle();
        bit            push_i, pop_i, rx_pop, ej_push;
        ient_t         ent;
        logic [LW-1:0] ed;
        push_i  = core_tx_valid && (injq.size() < 4);
        pop_i   = (injq.size() > 0) && in_accepted_inj;
        ent     = '{d: core_tx_data, a: core_tx_dst};
        ed      = out_data_ej;
        rx_pop  = (ejq.size() > 0) && core_rx_ready;
        ej_push = 0;
        if (injq.size() == 0 || pop_i) m_starve = 0;
        else if (m_starve < 16)        m_starve++;
        if (out_active_ej) begin
            if (out_srcdst_ej != ID)                m_mis = 1;
            else if (ejq.size() == 8 && !rx_pop)    m_ovf = 1;
            else                                    ej_push = 1;
        end
        @(posedge clock);
        #1;
        if (pop_i)  begin void'(injq.pop_front()); m_ic++; end
        if (push_i) injq.push_back(ent);
        if (rx_pop) void'(ejq.pop_front());
        if (ej_push) begin ejq.push_back(ed); m_ec++; end
        check_all();
    endtask

    task automatic idle_inputs();
        core_tx_valid   = 0;
        core_tx_data    = '0;
        core_tx_dst     = '0;
        in_accepted_inj = 0;
        out_active_ej   = 0;
        out_data_ej     = '0;
        out_srcdst_ej   = '0;
        core_rx_ready   = 0;
    endtask

    // Asynchronous reset: outputs must clear between clock edges
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        #2;
        chk("rst_tx_ready", core_tx_ready, 0);
        chk("rst_active",   in_active_inj, 0);
        chk("rst_inj_data", in_data_inj,   0);
        chk("rst_inj_dst",  in_srcdst_inj, 0);
        chk("rst_rx_valid", core_rx_valid, 0);
        chk("rst_rx_data",  core_rx_data,  0);
        chk("rst_flags",    {inj_starved, ej_overflow, ej_misroute}, 0);
        chk("rst_counts",   {inj_count, ej_count}, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
        model_reset();
        check_all();
    endtask

    task automatic eject(input logic [LW-1:0] d, input logic [AW-1:0] a);
        out_active_ej = 1;
        out_data_ej   = d;
        out_srcdst_ej = a;
        cycle();
        out_active_ej = 0;
    endtask

    initial begin
        ID = 4'd3;
        idle_inputs();
        reset = 0;
        #3;
        do_reset();

        // Three flits with the router always accepting
        in_accepted_inj = 1;
        core_tx_dst     = 4'd5;
        core_tx_valid   = 1;
        chk("t1_active_before", in_active_inj, 0);
        for (int k = 0; k < 3; k++) begin
            core_tx_data = 32'hA1 + k;
            cycle();
            chk("t1_head", in_data_inj, 32'hA1 + k);
        end
        core_tx_valid = 0;
        for (int k = 0; k < 3; k++) cycle();
        chk("t1_inj_count", inj_count, 3);

        // Blocked router: fill, starve, then a single accept
        in_accepted_inj = 0;
        core_tx_valid   = 1;
        for (int k = 0; k < 4; k++) begin
            core_tx_data = 32'hA1 + k;
            cycle();
        end
        core_tx_valid = 0;
        chk("t2_full_ready", core_tx_ready, 0);
        chk("t2_head", in_data_inj, 32'hA1);
        for (int k = 0; k < 16; k++) cycle();
        chk("t2_starved", inj_starved, 1);
        chk("t2_head_held", in_data_inj, 32'hA1);
        in_accepted_inj = 1;
        cycle();
        in_accepted_inj = 0;
        chk("t2_unstarved", inj_starved, 0);
        chk("t2_ready_back", core_tx_ready, 1);
        chk("t2_new_head", in_data_inj, 32'hA2);
        in_accepted_inj = 1;
        for (int k = 0; k < 3; k++) cycle();
        in_accepted_inj = 0;

        // Fill ejection FIFO then overflow it
        for (int k = 0; k < 9; k++) eject(32'hC0 + k, ID);
        chk("t3_overflow", ej_overflow, 1);
        chk("t3_ej_count", ej_count, 8);
        core_rx_ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk("t3_drain", core_rx_data, 32'hC0 + k);
            cycle();
        end
        core_rx_ready = 0;

        // Full FIFO with simultaneous core pop accepts the new flit
        do_reset();
        for (int k = 0; k < 8; k++) eject(32'hD0 + k, ID);
        core_rx_ready = 1;
        eject(32'hD8, ID);
        core_rx_ready = 0;
        chk("t4_no_overflow", ej_overflow, 0);
        chk("t4_ej_count", ej_count, 9);

        // Misrouted flit into an empty FIFO
        core_rx_ready = 1;
        for (int k = 0; k < 8; k++) cycle();
        core_rx_ready = 0;
        eject(32'hEE, ID + 4'd1);
        chk("t5_misroute", ej_misroute, 1);
        chk("t5_rx_valid", core_rx_valid, 0);
        chk("t5_ej_count", ej_count, 9);

        // Both FIFOs partly full, then asynchronous reset mid-stream
        core_tx_valid = 1;
        for (int k = 0; k < 2; k++) begin
            core_tx_data = 32'hF0 + k;
            cycle();
        end
        core_tx_valid = 0;
        for (int k = 0; k < 4; k++) eject(32'hB0 + k, ID);
        do_reset();
        chk("t6_ready", core_tx_ready, 1);
        chk("t6_rx_valid", core_rx_valid, 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            core_tx_valid   = ($urandom_range(0, 3) != 0);
            core_tx_data    = $urandom;
            core_tx_dst     = AW'($urandom);
            in_accepted_inj = ($urandom_range(0, 2) == 0);
            out_active_ej   = ($urandom_range(0, 1) == 1);
            out_data_ej     = $urandom;
            out_srcdst_ej   = ($urandom_range(0, 7) != 0) ? ID : AW'($urandom);
            core_rx_ready   = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bless_ni.md
Name: bless_ni

Overview:
- Per-node network interface sitting between a core and the BLESS deflection router's local port.
- It is the far end of the router's injection/ejection interface.
- Injection side: buffers core flits and presents the head flit on the injection port, holding it until the router accepts it.
- Ejection side: captures every ejected flit (the router cannot be back-pressured) into a receive FIFO drained by the core. It also provides starvation detection, error flags and traffic counters.

Parameters:
- INJ_DEPTH, 4, injection FIFO entries (power of 2, >=2)
- EJ_DEPTH, 8, ejection FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 16, consecutive unaccepted head cycles before inj_starved asserts
- CNTBITS, 16, width of traffic counters
- LINKWIDTH and ADDRBITS2 come from config.vh, not from parameters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ID  in  ADDRBITS2  this node's address
- core_tx_valid  in  1  core offers a flit
- core_tx_ready  out  1  NI can take the flit
- core_tx_data  in  LINKWIDTH  payload
- core_tx_dst  in  ADDRBITS2  destination address
- in_data_inj  out  LINKWIDTH  to router injection data
- in_srcdst_inj  out  ADDRBITS2  to router injection destination
- in_active_inj  out  1  injection flit valid
- in_accepted_inj  in  1  router consumed the injection flit this cycle
- out_data_ej  in  LINKWIDTH  ejected data from router
- out_srcdst_ej  in  ADDRBITS2  ejected destination
- out_active_ej  in  1  ejected flit valid
- core_rx_valid  out  1  received flit available
- core_rx_ready  in  1  core takes the flit
- core_rx_data  out  LINKWIDTH  received payload
- inj_starved  out  1  head blocked for at least STARVE_LIMIT cycles
- ej_overflow  out  1  sticky: ejected flit dropped because FIFO was full
- ej_misroute  out  1  sticky: ejected flit whose destination is not ID
- inj_count  out  CNTBITS  flits accepted by the router (wraps)
- ej_count  out  CNTBITS  flits written to the ejection FIFO (wraps)

Behaviour:
- Reset is asynchronous and active-high. While asserted, all state is cleared and the following outputs read 0:
  - in_active_inj, in_data_inj, in_srcdst_inj
  - core_tx_ready, core_rx_valid, core_rx_data
  - inj_starved, ej_overflow, ej_misroute
  - inj_count, ej_count
- Reset mid-operation discards the contents of both FIFOs.

Injection:
- core_tx_ready = !reset && (inj occupancy < INJ_DEPTH).
- Push occurs when core_tx_valid && core_tx_ready; the entry is {core_tx_data, core_tx_dst}.
- There is no bypass: a flit pushed into an empty FIFO appears on in_active_inj the next cycle.
- in_active_inj = FIFO non-empty. in_data_inj and in_srcdst_inj are the head entry, or 0 when the FIFO is empty.
- The head must stay stable until accepted.
- Pop occurs when in_active_inj && in_accepted_inj. in_accepted_inj is ignored while in_active_inj is 0.
- When full, core_tx_ready is 0 even if a pop happens in the same cycle (no pass-through).
- A push and a pop in the same cycle leave occupancy unchanged.
- inj_count increments on each pop.
- Starvation counter:
  - Increments each cycle in_active_inj && !in_accepted_inj, saturating at STARVE_LIMIT.
  - Clears on pop or when the FIFO is empty.
  - inj_starved = (counter == STARVE_LIMIT), registered, so it rises on the edge where the counter reaches the limit.

Ejection:
- out_active_ej, out_data_ej and out_srcdst_ej are sampled at the same clock edge.
- If out_srcdst_ej != ID, the flit is dropped, ej_misroute is set (sticky) and ej_count is not incremented.
- Otherwise, if the FIFO is full and no pop happens that cycle, the flit is dropped and ej_overflow is set (sticky).
- If the FIFO is full and core_rx_valid && core_rx_ready in the same cycle, the pop frees a slot and the push is accepted.
- Otherwise the flit is pushed and ej_count increments.
- Latency from out_active_ej to core_rx_valid is 1 cycle when the FIFO was empty.
- core_rx_data is the head entry, or 0 when the FIFO is empty.
- Sticky flags clear only on reset.
- Pointers wrap modulo depth. Occupancy is tracked with a log2(depth)+1-bit counter.

Decomposition:
- LINKWIDTH and ADDRBITS2 stay in the shared config.vh.
- Add NI_CNTBITS and STARVE_LIMIT defaults there as shared constants.
- One sub-module, ni_fifo, is instantiated twice:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata, empty, full, count.
  - Registered storage with an asynchronous reset.
  - Simultaneous push and pop is legal when full.

Test Plan:
- Reset, then push 3 flits (dst=5, data=0xA1..0xA3) with in_accepted_inj tied to 1 -> in_active_inj rises 1 cycle after the first push; flits exit in order, one per cycle; inj_count=3.
- Hold in_accepted_inj=0 and push 4 flits -> core_tx_ready=0 after the 4th push; head stays at 0xA1; inj_starved=1 after 16 blocked cycles. A single accept then pops the head, clears inj_starved and raises core_tx_ready the next cycle.
- Inject 8 ejected flits addressed to ID with core_rx_ready=0, then a 9th -> ej_overflow=1, ej_count=8; draining returns flits 1..8 in order.
- With the ejection FIFO full, present a flit while the core pops the head in the same cycle -> flit is accepted, ej_overflow stays 0, ej_count increments.
- Present an ejected flit with srcdst = ID+1 -> ej_misroute=1, core_rx_valid stays 0, ej_count unchanged.
- Assert reset mid-stream with both FIFOs half full -> all outputs 0 immediately (asynchronously); after release core_tx_ready=1 and core_rx_valid=0.
